// File: rtl/rv32i_interrupt_sequencer_pkg.sv
// Shared encodings for the interrupt sequencer: its own FSM states and the
// controller-side interrupt_state codes it observes.
package rv32i_interrupt_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_TAKE    = 2'b01,
    ST_HANDLER = 2'b10,
    ST_RETURN  = 2'b11
  } seq_state_e;

  localparam logic [1:0] IRQ_IDLE    = 2'b00;
  localparam logic [1:0] IRQ_PEND    = 2'b01;
  localparam logic [1:0] IRQ_SERVICE = 2'b10;

endpackage

// File: rtl/rv32i_interrupt_sequencer.sv
// Core-side interrupt entry/return sequencer: takes a pending request at an
// instruction boundary, redirects fetch to the vector, and restores on mret.
module rv32i_interrupt_sequencer
  import rv32i_interrupt_sequencer_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic [1:0]      interrupt_state_i,
  input  logic [XLEN-1:0] interrupt_vector_offset_i,
  output logic            interrupt_advance_o,
  output logic            clear_interrupt_o,
  input  logic [XLEN-1:0] vector_base_i,
  input  logic            instr_boundary_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic            mret_i,
  output logic            redirect_valid_o,
  output logic [XLEN-1:0] redirect_pc_o,
  input  logic            redirect_ready_i,
  input  logic            mie_write_i,
  input  logic            mie_data_i,
  output logic            mie_o,
  output logic [XLEN-1:0] epc_o,
  output logic            in_handler_o,
  output logic            spurious_mret_o
);

  seq_state_e      state_q, state_d;
  logic            mie_q, mie_d;
  logic            mpie_q, mpie_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic [XLEN-1:0] target_q, target_d;
  logic            advance_q, advance_d;
  logic            clear_q, clear_d;
  logic            spurious_q, spurious_d;
  logic            take;
  logic            handshake;

  assign take      = (interrupt_state_i == IRQ_PEND) & mie_q & instr_boundary_i;
  assign handshake = redirect_valid_o & redirect_ready_i;

  always_comb begin
    state_d    = state_q;
    mie_d      = mie_q;
    mpie_d     = mpie_q;
    epc_d      = epc_q;
    target_d   = target_q;
    advance_d  = 1'b0;
    clear_d    = 1'b0;
    spurious_d = 1'b0;
    // Outside IDLE a CSR write goes to mpie so mret restores the written value.
    if (mie_write_i && state_q != ST_IDLE) begin
      mpie_d = mie_data_i;
    end
    unique case (state_q)
      ST_IDLE: begin
        spurious_d = mret_i & ~spurious_q;
        if (take) begin
          epc_d    = pc_i;
          target_d = vector_base_i + interrupt_vector_offset_i;
          mpie_d   = mie_write_i ? mie_data_i : mie_q;
          mie_d    = 1'b0;
          state_d  = ST_TAKE;
        end else if (mie_write_i) begin
          mie_d = mie_data_i;
        end
      end
      ST_TAKE: begin
        if (handshake) begin
          advance_d = 1'b1;
          state_d   = ST_HANDLER;
        end
      end
      ST_HANDLER: begin
        if (mret_i) begin
          mie_d    = mie_write_i ? mie_data_i : mpie_q;
          target_d = epc_q;
          clear_d  = 1'b1;
          state_d  = ST_RETURN;
        end
      end
      ST_RETURN: begin
        if (handshake) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      epc_q      <= '0;
      target_q   <= '0;
      advance_q  <= 1'b0;
      clear_q    <= 1'b0;
      spurious_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mie_q      <= mie_d;
      mpie_q     <= mpie_d;
      epc_q      <= epc_d;
      target_q   <= target_d;
      advance_q  <= advance_d;
      clear_q    <= clear_d;
      spurious_q <= spurious_d;
    end
  end

  assign redirect_valid_o    = (state_q == ST_TAKE) || (state_q == ST_RETURN);
  assign redirect_pc_o       = redirect_valid_o ? target_q : '0;
  assign interrupt_advance_o = advance_q;
  assign clear_interrupt_o   = clear_q;
  assign spurious_mret_o     = spurious_q;
  assign mie_o               = mie_q;
  assign epc_o               = epc_q;
  assign in_handler_o        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_rv32i_interrupt_sequencer.sv
// Directed bench for the interrupt sequencer: entry, stalled redirect,
// return, masked requests, CSR writes in handler, spurious mret, reset, wrap.
module tb_rv32i_interrupt_sequencer;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [1:0]  interrupt_state_i;
  logic [31:0] interrupt_vector_offset_i;
  logic        interrupt_advance_o;
  logic        clear_interrupt_o;
  logic [31:0] vector_base_i;
  logic        instr_boundary_i;
  logic [31:0] pc_i;
  logic        mret_i;
  logic        redirect_valid_o;
  logic [31:0] redirect_pc_o;
  logic        redirect_ready_i;
  logic        mie_write_i;
  logic        mie_data_i;
  logic        mie_o;
  logic [31:0] epc_o;
  logic        in_handler_o;
  logic        spurious_mret_o;

  int n_compared = 0;
  int n_mismatched = 0;

  rv32i_interrupt_sequencer #(.XLEN(32)) dut (
    .clk_i                     (clk_i),
    .reset_i                   (reset_i),
    .interrupt_state_i         (interrupt_state_i),
    .interrupt_vector_offset_i (interrupt_vector_offset_i),
    .interrupt_advance_o       (interrupt_advance_o),
    .clear_interrupt_o         (clear_interrupt_o),
    .vector_base_i             (vector_base_i),
    .instr_boundary_i          (instr_boundary_i),
    .pc_i                      (pc_i),
    .mret_i                    (mret_i),
    .redirect_valid_o          (redirect_valid_o),
    .redirect_pc_o             (redirect_pc_o),
    .redirect_ready_i          (redirect_ready_i),
    .mie_write_i               (mie_write_i),
    .mie_data_i                (mie_data_i),
    .mie_o                     (mie_o),
    .epc_o                     (epc_o),
    .in_handler_o              (in_handler_o),
    .spurious_mret_o           (spurious_mret_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, ".valid"},    redirect_valid_o, 0);
    check_eq({tag, ".pc"},       redirect_pc_o, 0);
    check_eq({tag, ".mie"},      mie_o, 0);
    check_eq({tag, ".epc"},      epc_o, 0);
    check_eq({tag, ".inh"},      in_handler_o, 0);
    check_eq({tag, ".advance"},  interrupt_advance_o, 0);
    check_eq({tag, ".clear"},    clear_interrupt_o, 0);
    check_eq({tag, ".spurious"}, spurious_mret_o, 0);
  endtask

  initial begin
    reset_i = 1'b1;
    interrupt_state_i = 2'b00;
    interrupt_vector_offset_i = '0;
    vector_base_i = '0;
    instr_boundary_i = 1'b0;
    pc_i = '0;
    mret_i = 1'b0;
    redirect_ready_i = 1'b0;
    mie_write_i = 1'b0;
    mie_data_i = 1'b0;
    step();
    step();
    reset_i = 1'b0;
    check_all_zero("reset");

    // 1: entry
    mie_write_i = 1'b1; mie_data_i = 1'b1;
    step();
    mie_write_i = 1'b0;
    check_eq("t1.mie_set", mie_o, 1);
    vector_base_i = 32'h100; interrupt_vector_offset_i = 32'h8;
    interrupt_state_i = 2'b01; instr_boundary_i = 1'b1; pc_i = 32'h2000;
    step();
    instr_boundary_i = 1'b0;
    check_eq("t1.valid", redirect_valid_o, 1);
    check_eq("t1.pc",    redirect_pc_o, 32'h108);
    check_eq("t1.epc",   epc_o, 32'h2000);
    check_eq("t1.mie",   mie_o, 0);
    check_eq("t1.inh",   in_handler_o, 1);

    // 2: stalled redirect
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("t2.hold_valid", redirect_valid_o, 1);
      check_eq("t2.hold_pc",    redirect_pc_o, 32'h108);
      check_eq("t2.no_advance", interrupt_advance_o, 0);
    end
    redirect_ready_i = 1'b1;
    step();
    redirect_ready_i = 1'b0;
    interrupt_state_i = 2'b10;
    check_eq("t2.advance",   interrupt_advance_o, 1);
    check_eq("t2.valid_off", redirect_valid_o, 0);
    check_eq("t2.inh",       in_handler_o, 1);
    step();
    check_eq("t2.advance_once", interrupt_advance_o, 0);

    // 3: mret in handler
    mret_i = 1'b1;
    step();
    mret_i = 1'b0;
    check_eq("t3.clear", clear_interrupt_o, 1);
    check_eq("t3.valid", redirect_valid_o, 1);
    check_eq("t3.pc",    redirect_pc_o, 32'h2000);
    check_eq("t3.mie",   mie_o, 1);
    step();
    check_eq("t3.clear_once", clear_interrupt_o, 0);
    check_eq("t3.valid_hold", redirect_valid_o, 1);
    redirect_ready_i = 1'b1;
    interrupt_state_i = 2'b00;
    step();
    redirect_ready_i = 1'b0;
    check_eq("t3.valid_off", redirect_valid_o, 0);
    check_eq("t3.idle",      in_handler_o, 0);

    // 4: masked request, then enable
    mie_write_i = 1'b1; mie_data_i = 1'b0;
    step();
    mie_write_i = 1'b0;
    check_eq("t4.mie_clr", mie_o, 0);
    interrupt_state_i = 2'b01; instr_boundary_i = 1'b1;
    interrupt_vector_offset_i = 32'hC; pc_i = 32'h3000;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("t4.masked", redirect_valid_o, 0);
    end
    instr_boundary_i = 1'b0;
    mie_write_i = 1'b1; mie_data_i = 1'b1;
    step();
    mie_write_i = 1'b0;
    check_eq("t4.mie_set",  mie_o, 1);
    check_eq("t4.no_bound", redirect_valid_o, 0);
    instr_boundary_i = 1'b1;
    step();
    instr_boundary_i = 1'b0;
    check_eq("t4.valid", redirect_valid_o, 1);
    check_eq("t4.pc",    redirect_pc_o, 32'h10C);
    check_eq("t4.epc",   epc_o, 32'h3000);

    // 5: mie write in handler, then mret; spurious mret in IDLE
    redirect_ready_i = 1'b1;
    step();
    redirect_ready_i = 1'b0;
    interrupt_state_i = 2'b10;
    check_eq("t5.advance", interrupt_advance_o, 1);
    mie_write_i = 1'b1; mie_data_i = 1'b0;
    step();
    mie_write_i = 1'b0;
    check_eq("t5.mie_in_handler", mie_o, 0);
    mret_i = 1'b1;
    step();
    mret_i = 1'b0;
    check_eq("t5.clear", clear_interrupt_o, 1);
    check_eq("t5.pc",    redirect_pc_o, 32'h3000);
    check_eq("t5.mie",   mie_o, 0);
    redirect_ready_i = 1'b1;
    interrupt_state_i = 2'b00;
    step();
    redirect_ready_i = 1'b0;
    check_eq("t5.idle",     in_handler_o, 0);
    check_eq("t5.mie_kept", mie_o, 0);
    mret_i = 1'b1;
    step();
    mret_i = 1'b0;
    check_eq("t5.spurious",    spurious_mret_o, 1);
    check_eq("t5.sp_noclear",  clear_interrupt_o, 0);
    check_eq("t5.sp_novalid",  redirect_valid_o, 0);
    step();
    check_eq("t5.spurious_once", spurious_mret_o, 0);

    // 6: wrapped target, then reset while in TAKE
    mie_write_i = 1'b1; mie_data_i = 1'b1;
    step();
    mie_write_i = 1'b0;
    vector_base_i = 32'hFFFF_FFFC; interrupt_vector_offset_i = 32'h8;
    interrupt_state_i = 2'b01; instr_boundary_i = 1'b1; pc_i = 32'h4000;
    step();
    instr_boundary_i = 1'b0;
    check_eq("t6.valid",   redirect_valid_o, 1);
    check_eq("t6.wrap_pc", redirect_pc_o, 32'h4);
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    interrupt_state_i = 2'b00;
    check_all_zero("t6.reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
